// File: rtl/max7219_scroller.sv
// rtl/max7219_scroller.sv - scrolling 8-column window source for a MAX7219 8x8 driver
//
// Ports:
//   clk, rst          system clock, synchronous active-high reset
//   wr_en/addr/data   column buffer write port (bit r of a column = row r, bit0 = top)
//   msg_len           number of valid message columns (0..DEPTH)
//   enable            allow frame-driven scrolling
//   step_div          display frames per one-column step (0 behaves as 1)
//   refresh           pulse: rebuild the window at the current offset
//   frame_done        driver finish level, asynchronous to clk
//   pixels            committed window; row r is pixels[63-8r -: 8], MSB = leftmost column
//   offset            buffer index of the leftmost displayed column
//   busy              window load in progress
//   wrapped           one-cycle pulse when offset wraps to 0
module max7219_scroller #(
    parameter int DEPTH = 64,
    parameter int AW    = 6,
    parameter int DIV_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             wr_en,
    input  logic [AW-1:0]    wr_addr,
    input  logic [7:0]       wr_data,
    input  logic [AW:0]      msg_len,
    input  logic             enable,
    input  logic [DIV_W-1:0] step_div,
    input  logic             refresh,
    input  logic             frame_done,
    output logic [63:0]      pixels,
    output logic [AW-1:0]    offset,
    output logic             busy,
    output logic             wrapped
);

    typedef enum logic [1:0] {IDLE, READ, DRAIN, COMMIT} state_t;

    state_t state, state_next;

    logic [7:0]       mem [DEPTH];
    logic [7:0]       rd_data;
    logic             sync1, sync2, sync3;
    logic [DIV_W-1:0] frame_cnt;
    logic             pending;
    logic [AW:0]      len_q;
    logic [AW-1:0]    idx;
    logic [2:0]       col_cnt;
    logic [63:0]      shadow;

    logic             frame_tick;
    logic [DIV_W:0]   div_lim;
    logic [DIV_W:0]   cnt_inc;
    logic             step;
    logic [AW:0]      off_inc;
    logic [AW-1:0]    offset_next;
    logic [AW-1:0]    start_idx;
    logic [AW:0]      idx_inc;
    logic             load_req;
    logic             start;
    logic [2:0]       col_sel;

    assign frame_tick = sync2 & ~sync3;
    assign div_lim    = (step_div == '0) ? (DIV_W+1)'(1) : {1'b0, step_div};
    assign cnt_inc    = {1'b0, frame_cnt} + (DIV_W+1)'(1);
    assign step       = enable & frame_tick & (cnt_inc >= div_lim);
    assign off_inc    = {1'b0, offset} + (AW+1)'(1);
    assign offset_next = step ? ((off_inc >= msg_len) ? '0 : off_inc[AW-1:0]) : offset;
    // A load always starts from the offset being committed this cycle, so a
    // step and its own load agree; a stale offset beyond msg_len reads from 0.
    assign start_idx  = ({1'b0, offset_next} >= msg_len) ? '0 : offset_next;
    assign idx_inc    = {1'b0, idx} + (AW+1)'(1);
    assign load_req   = step | refresh;
    // Requests landing in COMMIT chain straight into the next load.
    assign start      = ((state == IDLE) && load_req) ||
                        ((state == COMMIT) && (pending || load_req));
    // Read data trails the issued address by one cycle; in DRAIN col_cnt has
    // wrapped to 0 so this yields column 7.
    assign col_sel    = col_cnt - 3'd1;
    assign busy       = (state != IDLE);

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (load_req) state_next = READ;
            READ:    if (col_cnt == 3'd7) state_next = DRAIN;
            DRAIN:   state_next = COMMIT;
            COMMIT:  state_next = (pending || load_req) ? READ : IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (wr_en && ({1'b0, wr_addr} < (AW+1)'(DEPTH)))
            mem[wr_addr] <= wr_data;
        if (state == READ)
            rd_data <= mem[idx];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sync1     <= 1'b0;
            sync2     <= 1'b0;
            sync3     <= 1'b0;
            frame_cnt <= '0;
            offset    <= '0;
            wrapped   <= 1'b0;
            pending   <= 1'b0;
            len_q     <= '0;
            idx       <= '0;
            col_cnt   <= '0;
            shadow    <= '0;
            pixels    <= '0;
        end else begin
            sync1 <= frame_done;
            sync2 <= sync1;
            sync3 <= sync2;
            if (enable && frame_tick)
                frame_cnt <= step ? '0 : cnt_inc[DIV_W-1:0];

            offset  <= offset_next;
            wrapped <= step && (offset_next == '0) && (offset != '0) && (msg_len != '0);

            if (start)
                pending <= 1'b0;
            else if (load_req && busy)
                pending <= 1'b1;

            if (start) begin
                len_q   <= msg_len;
                idx     <= start_idx;
                col_cnt <= '0;
            end else if (state == READ) begin
                idx     <= (idx_inc >= len_q) ? '0 : idx_inc[AW-1:0];
                col_cnt <= col_cnt + 3'd1;
            end

            // Column c, row r lands at bit 63-8r-c = {7-r, 7-c}.
            if (((state == READ) && (col_cnt != 3'd0)) || (state == DRAIN)) begin
                for (int r = 0; r < 8; r++)
                    shadow[{3'(7 - r), ~col_sel}] <= rd_data[r];
            end

            if (state == COMMIT)
                pixels <= (len_q == '0) ? '0 : shadow;
        end
    end

endmodule

// File: tb/tb_max7219_scroller.sv
// tb/tb_max7219_scroller.sv - self-checking bench for max7219_scroller
module tb_max7219_scroller;

    localparam int DEPTH = 64;
    localparam int AW    = 6;
    localparam int DIV_W = 8;

    logic             clk = 1'b0;
    logic             rst;
    logic             wr_en;
    logic [AW-1:0]    wr_addr;
    logic [7:0]       wr_data;
    logic [AW:0]      msg_len;
    logic             enable;
    logic [DIV_W-1:0] step_div;
    logic             refresh;
    logic             frame_done;
    logic [63:0]      pixels;
    logic [AW-1:0]    offset;
    logic             busy;
    logic             wrapped;

    max7219_scroller #(.DEPTH(DEPTH), .AW(AW), .DIV_W(DIV_W)) dut (
        .clk(clk), .rst(rst), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .msg_len(msg_len), .enable(enable), .step_div(step_div), .refresh(refresh),
        .frame_done(frame_done), .pixels(pixels), .offset(offset), .busy(busy),
        .wrapped(wrapped)
    );

    always #5 clk = ~clk;

    int vectors = 0;
    int miscompares = 0;
    logic [7:0]  ref_mem [DEPTH];
    int          ref_off = 0;
    int          ref_cnt = 0;
    logic [63:0] ref_pix = '0;
    int          busy_seen = 0;
    int          wrap_seen = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        busy_seen += int'(busy);
        wrap_seen += int'(wrapped);
    endtask

    function automatic logic [63:0] window(input int off, input int len);
        logic [63:0] w;
        logic [7:0]  col;
        int          start;
        w = '0;
        if (len == 0) return w;
        start = (off >= len) ? 0 : off;
        for (int c = 0; c < 8; c++) begin
            col = ref_mem[(start + c) % len];
            for (int r = 0; r < 8; r++)
                w[63 - 8*r - c] = col[r];
        end
        return w;
    endfunction

    task automatic wr(input int a, input logic [7:0] d);
        wr_en = 1'b1; wr_addr = AW'(a); wr_data = d;
        tick();
        wr_en = 1'b0;
        ref_mem[a] = d;
    endtask

    task automatic wait_idle();
        int n = 0;
        while (busy && n < 200) begin
            tick();
            n++;
        end
        if (busy) check("idle_timeout", 64'(busy), 64'd0);
    endtask

    task automatic do_refresh();
        refresh = 1'b1;
        tick();
        refresh = 1'b0;
        wait_idle();
        ref_pix = window(ref_off, int'(msg_len));
    endtask

    // Reference: a frame advances the counter only while enabled; every
    // max(step_div,1) frames the window moves one column, wrapping at msg_len.
    task automatic frame_pulse();
        int lim;
        frame_done = 1'b1;
        repeat (4) tick();
        frame_done = 1'b0;
        repeat (4) tick();
        if (enable) begin
            lim = (step_div == 0) ? 1 : int'(step_div);
            ref_cnt++;
            if (ref_cnt >= lim) begin
                ref_cnt = 0;
                ref_off = (ref_off + 1 >= int'(msg_len)) ? 0 : ref_off + 1;
                ref_pix = window(ref_off, int'(msg_len));
            end
        end
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        ref_off = 0;
        ref_cnt = 0;
        ref_pix = '0;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1; wr_en = 1'b0; wr_addr = '0; wr_data = '0; msg_len = '0;
        enable = 1'b0; step_div = 8'd1; refresh = 1'b0; frame_done = 1'b0;
        repeat (3) tick();
        check("rst_pixels", pixels, 64'd0);
        check("rst_offset", 64'(offset), 64'd0);
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_wrapped", 64'(wrapped), 64'd0);
        rst = 1'b0;
        tick();

        // Diagonal pattern with exact load latency
        for (int i = 0; i < 8; i++) wr(i, 8'h01 << i);
        msg_len = 7'd8;
        busy_seen = 0;
        refresh = 1'b1;
        tick();
        refresh = 1'b0;
        repeat (9) tick();
        check("latency_hold", pixels, 64'd0);
        tick();
        check("diag_pixels", pixels, 64'h8040201008040201);
        check("diag_model", pixels, window(0, 8));
        check("diag_busy_cycles", 64'(busy_seen), 64'd10);

        // Random buffer contents, random lengths, refresh at offset 0
        for (int i = 0; i < DEPTH; i++) wr(i, 8'($urandom));
        for (int k = 0; k < 6; k++) begin
            msg_len = 7'($urandom_range(1, 64));
            do_refresh();
            check("rand_refresh", pixels, ref_pix);
        end

        // Stepping every two frames over a 10-column message
        msg_len = 7'd10; step_div = 8'd2; enable = 1'b1;
        for (int p = 1; p <= 6; p++) begin
            frame_pulse();
            wait_idle();
            check("step_offset", 64'(offset), 64'(p / 2));
            check("step_model_off", 64'(offset), 64'(ref_off));
            check("step_pixels", pixels, ref_pix);
        end

        // Walk to the last column, then wrap
        step_div = 8'd1;
        while (ref_off != 9) begin
            frame_pulse();
            wait_idle();
        end
        check("pre_wrap_offset", 64'(offset), 64'd9);
        wrap_seen = 0;
        frame_pulse();
        wait_idle();
        check("wrap_offset", 64'(offset), 64'd0);
        check("wrap_pulses", 64'(wrap_seen), 64'd1);
        check("wrap_pixels", pixels, window(0, 10));

        // Disabled: frames ignored
        enable = 1'b0;
        repeat (3) frame_pulse();
        wait_idle();
        check("disabled_offset", 64'(offset), 64'(ref_off));

        // Randomized stepping with varying divider, length and enable
        for (int k = 0; k < 24; k++) begin
            step_div = 8'($urandom_range(0, 3));
            enable = ($urandom_range(0, 5) != 0);
            if ($urandom_range(0, 3) == 0) msg_len = 7'($urandom_range(0, 64));
            frame_pulse();
            wait_idle();
            check("rand_offset", 64'(offset), 64'(ref_off));
            check("rand_pixels", pixels, ref_pix);
        end

        // Short message repeats cyclically
        enable = 1'b0;
        do_reset();
        wr(0, 8'hAA); wr(1, 8'h55); wr(2, 8'hFF);
        msg_len = 7'd3;
        do_refresh();
        check("short_pixels", pixels, 64'h6DB66DB66DB66DB6);
        check("short_model", pixels, ref_pix);

        // Two steps plus a refresh during a load coalesce into one extra load
        for (int i = 3; i < 10; i++) wr(i, 8'($urandom));
        msg_len = 7'd10; step_div = 8'd1; enable = 1'b1;
        busy_seen = 0;
        frame_done = 1'b1;
        repeat (4) tick();
        frame_done = 1'b0;
        refresh = 1'b1;
        tick();
        refresh = 1'b0;
        repeat (2) tick();
        frame_done = 1'b1;
        repeat (4) tick();
        frame_done = 1'b0;
        repeat (30) tick();
        ref_off = 2;
        check("coalesce_busy", 64'(busy_seen), 64'd20);
        check("coalesce_offset", 64'(offset), 64'(ref_off));
        check("coalesce_pixels", pixels, window(ref_off, 10));

        // Reset in the middle of a load
        enable = 1'b0;
        msg_len = 7'd8;
        refresh = 1'b1;
        tick();
        refresh = 1'b0;
        repeat (3) tick();
        rst = 1'b1;
        tick();
        check("midload_rst_pixels", pixels, 64'd0);
        check("midload_rst_offset", 64'(offset), 64'd0);
        check("midload_rst_busy", 64'(busy), 64'd0);
        rst = 1'b0;
        ref_off = 0; ref_cnt = 0;
        do_refresh();
        check("post_rst_pixels", pixels, ref_pix);

        // Empty message yields a blank window
        msg_len = '0;
        do_refresh();
        check("empty_pixels", pixels, 64'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
